// File: rtl/register_file_pkg.sv
// Shared register-file geometry and the MIPS ALU operation codes used by the datapath.
package register_file_pkg;

    localparam int unsigned RegDataWidth = 32;
    localparam int unsigned RegAddrWidth = 5;
    localparam int unsigned RegCount     = 2 ** RegAddrWidth;

    localparam logic [RegAddrWidth-1:0] REG_ZERO = 5'd0;

    // 3'b011 and 3'b111 are unused encodings.
    typedef enum logic [2:0] {
        AluAnd  = 3'b000,
        AluOr   = 3'b001,
        AluAdd  = 3'b010,
        AluSub  = 3'b100,
        AluMult = 3'b101,
        AluSlt  = 3'b110
    } alu_op_e;

endpackage

// File: rtl/register_file.sv
// MIPS architectural register file: two combinational read ports, one clocked write port,
// a never-bypassed debug read port, and $0 hardwired to zero.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RegDataWidth,
    parameter int unsigned ADDR_WIDTH = RegAddrWidth,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    // Entry 0 has no storage; the array starts at index 1.
    logic [DATA_WIDTH-1:0] regs [1:NumRegs-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable && (write_addr != '0)) begin
            regs[write_addr] <= write_data;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_mux(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic                  allow_bypass);
        logic [DATA_WIDTH-1:0] data;
        data = '0;
        if (addr != '0) begin
            if (allow_bypass && write_enable && (write_addr == addr)) begin
                data = write_data;
            end else begin
                data = regs[addr];
            end
        end
        return data;
    endfunction

    always_comb begin
        read_data_a = read_mux(read_addr_a, BYPASS);
        read_data_b = read_mux(read_addr_b, BYPASS);
        debug_data  = read_mux(debug_addr, 1'b0);
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: one bypassing and one non-bypassing instance share stimulus.
module tb_register_file;
    import register_file_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  read_addr_a, read_addr_b, write_addr, debug_addr;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] rda_b, rdb_b, dbg_b;
    logic [31:0] rda_n, rdb_n, dbg_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
        alu_op_e     op;
    } item_t;

    item_t sb_q[$];
    event  check_ev;

    always #5 clk = ~clk;

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst(rst),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(rda_b), .read_data_b(rdb_b),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .debug_addr(debug_addr), .debug_data(dbg_b)
    );

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) u_nob (
        .clk(clk), .rst(rst),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(rda_n), .read_data_b(rdb_n),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .debug_addr(debug_addr), .debug_data(dbg_n)
    );

    // Reference ALU fed by the bypassing instance's read ports.
    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        case (op)
            AluAnd:  return a & b;
            AluOr:   return a | b;
            AluAdd:  return a + b;
            AluSub:  return a - b;
            AluMult: return prod[31:0];
            AluSlt:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input item_t it);
        logic [31:0] r;
        case (it.sel)
            0:       return rda_b;
            1:       return rdb_b;
            2:       return rda_n;
            3:       return rdb_n;
            4:       return dbg_b;
            5:       return dbg_n;
            6:       return alu(it.op, rda_b, rdb_b);
            7: begin
                r = alu(it.op, rda_b, rdb_b);
                return {31'd0, r == 32'd0};
            end
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: compares every queued expectation when a sample point is signalled.
    initial begin
        item_t       it;
        logic [31:0] got;
        forever begin
            @(check_ev);
            while (sb_q.size() > 0) begin
                it  = sb_q.pop_front();
                got = pick(it);
                checks++;
                if (got !== it.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", it.name, got, it.exp,
                             $time);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [31:0] exp,
                              input alu_op_e op = AluAdd);
        item_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = exp;
        it.op   = op;
        sb_q.push_back(it);
    endtask

    task automatic sample();
        ->check_ev;
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        write_enable = 1'b1;
        write_addr   = addr;
        write_data   = data;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        read_addr_a  = '0;
        read_addr_b  = '0;
        write_addr   = '0;
        write_data   = '0;
        write_enable = 1'b0;
        debug_addr   = '0;
        #2;
        read_addr_a = 5'd7;
        debug_addr  = 5'd9;
        #1;
        expect_val("reset_rda", 0, 32'h0);
        expect_val("reset_dbg", 4, 32'h0);
        sample();
        @(negedge clk);
        rst = 1'b0;

        // Fill r1..r31 with all ones, then reset between edges.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'hFFFF_FFFF);
        read_addr_a = 5'd1;
        read_addr_b = 5'd17;
        debug_addr  = 5'd31;
        #1;
        expect_val("fill_r1", 0, 32'hFFFF_FFFF);
        expect_val("fill_dbg31", 5, 32'hFFFF_FFFF);
        sample();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        expect_val("async_rst_rda", 0, 32'h0);
        expect_val("async_rst_rdb", 3, 32'h0);
        expect_val("async_rst_dbg", 4, 32'h0);
        sample();
        for (int i = 1; i < 32; i++) begin
            debug_addr = 5'(i);
            #1;
            expect_val($sformatf("rst_dbg_r%0d", i), 4, 32'h0);
            expect_val($sformatf("rst_dbgn_r%0d", i), 5, 32'h0);
            sample();
        end
        @(negedge clk);
        rst = 1'b0;

        // Zero register ignores writes, even on the bypass path.
        @(negedge clk);
        write_enable = 1'b1;
        write_addr   = 5'd0;
        write_data   = 32'h1234_5678;
        read_addr_a  = 5'd0;
        debug_addr   = 5'd0;
        #1;
        expect_val("r0_bypass_rda", 0, 32'h0);
        sample();
        @(negedge clk);
        write_enable = 1'b0;
        #1;
        expect_val("r0_rda", 0, 32'h0);
        expect_val("r0_dbg", 4, 32'h0);
        sample();

        // ALU feed.
        wr(5'd1, 32'd550);
        wr(5'd2, 32'd450);
        read_addr_a = 5'd1;
        read_addr_b = 5'd2;
        #1;
        expect_val("alu_a", 0, 32'h226);
        expect_val("alu_b", 1, 32'h1C2);
        expect_val("alu_add", 6, 32'h3E8, AluAdd);
        expect_val("alu_sub", 6, 32'h64, AluSub);
        expect_val("alu_and", 6, 32'h2, AluAnd);
        expect_val("alu_or", 6, 32'h3E6, AluOr);
        expect_val("alu_mult", 6, 32'h3C6CC, AluMult);
        expect_val("alu_slt", 6, 32'h0, AluSlt);
        expect_val("alu_slt_zero", 7, 32'h1, AluSlt);
        sample();
        wr(5'd1, 32'd100);
        #1;
        expect_val("alu_slt2", 6, 32'h1, AluSlt);
        expect_val("alu_slt2_zero", 7, 32'h0, AluSlt);
        sample();

        // Read-during-write on r5.
        @(negedge clk);
        write_enable = 1'b1;
        write_addr   = 5'd5;
        write_data   = 32'hDEAD_BEEF;
        read_addr_a  = 5'd5;
        read_addr_b  = 5'd5;
        debug_addr   = 5'd5;
        #1;
        expect_val("byp_rda", 0, 32'hDEAD_BEEF);
        expect_val("byp_rdb", 1, 32'hDEAD_BEEF);
        expect_val("nobyp_rda", 2, 32'h0);
        expect_val("nobyp_rdb", 3, 32'h0);
        expect_val("byp_dbg_old", 4, 32'h0);
        sample();
        @(posedge clk);
        #1;
        expect_val("nobyp_rda_post", 2, 32'hDEAD_BEEF);
        expect_val("nobyp_rdb_post", 3, 32'hDEAD_BEEF);
        expect_val("dbg_post", 4, 32'hDEAD_BEEF);
        sample();
        @(negedge clk);
        write_enable = 1'b0;

        // Write gating and back-to-back writes on r3.
        @(negedge clk);
        write_addr  = 5'd3;
        write_data  = 32'hAAAA;
        debug_addr  = 5'd3;
        read_addr_a = 5'd3;
        @(negedge clk);
        #1;
        expect_val("gated_dbg", 4, 32'h0);
        expect_val("gated_rda", 0, 32'h0);
        sample();
        @(negedge clk);
        write_enable = 1'b1;
        write_data   = 32'd7;
        @(posedge clk);
        #1;
        expect_val("b2b_first", 5, 32'd7);
        sample();
        @(negedge clk);
        write_data = 32'd9;
        @(posedge clk);
        #1;
        expect_val("b2b_last", 5, 32'd9);
        sample();
        @(negedge clk);
        write_enable = 1'b0;

        // Reset asserted half a cycle before an edge carrying a write to r4.
        @(negedge clk);
        write_enable = 1'b1;
        write_addr   = 5'd4;
        write_data   = 32'h55;
        read_addr_a  = 5'd4;
        debug_addr   = 5'd4;
        rst          = 1'b1;
        #1;
        expect_val("rst_byp_shows_wd", 0, 32'h55);
        expect_val("rst_nobyp_zero", 2, 32'h0);
        sample();
        @(posedge clk);
        #1;
        expect_val("rst_write_blocked", 4, 32'h0);
        sample();
        @(negedge clk);
        write_enable = 1'b0;
        rst          = 1'b0;
        #1;
        expect_val("rst_release_r4", 5, 32'h0);
        expect_val("rst_release_r3", 2, 32'h0);
        sample();
        // First edge after release commits.
        wr(5'd4, 32'h66);
        #1;
        expect_val("post_release_write", 4, 32'h66);
        sample();

        begin
            int budget = 100;
            while (sb_q.size() > 0 && budget > 0) begin
                #1;
                budget--;
            end
            if (sb_q.size() > 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
